wb_arbiter_rr2: RTL
===================

Name: wb_arbiter_rr2

Overview:
- Two-master, one-slave Wishbone round-robin arbiter for the shared SoC bus.
- Sits between the LM32 instruction and data ports and the address-decoding interconnect, so a single granted master reaches the decoder at a time.
- Holds each grant for the master's whole cycle (cyc high) and never preempts it.
- A bus watchdog terminates any strobe the addressed slave never answers, with an error to the owning master.

Parameters:
- TIMEOUT, 1023: stalled-strobe cycles before abort. Range 0..65535. 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m0_adr_i / m1_adr_i  in  32  master address.
- m0_dat_i / m1_dat_i  in  32  master write data.
- m0_dat_o / m1_dat_o  out  32  read data (both = s_dat_i).
- m0_sel_i / m1_sel_i  in  4  byte selects.
- m0_we_i / m1_we_i  in  1  write enable.
- m0_cyc_i / m1_cyc_i  in  1  cycle request.
- m0_stb_i / m1_stb_i  in  1  strobe.
- m0_ack_o / m1_ack_o  out  1  acknowledge, gated by grant.
- m0_err_o / m1_err_o  out  1  error, gated by grant.
- s_adr_o  out  32  address to interconnect.
- s_dat_o  out  32  write data to interconnect.
- s_sel_o  out  4  byte selects to interconnect.
- s_we_o  out  1  write enable to interconnect.
- s_cyc_o  out  1  cycle to interconnect.
- s_stb_o  out  1  strobe to interconnect.
- s_dat_i  in  32  read data from slave.
- s_ack_i  in  1  acknowledge from slave.
- s_err_i  in  1  error from slave.
- grant_o  out  2  one-hot owner (bit0 = m0). 00 means idle.
- timeout_o  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Registered state: IDLE, OWN0, OWN1. Also registered: last (last served master), stall counter cnt[15:0], tmo flag.
- Reset (sampled at clk edge):
  - state=IDLE, last=1, cnt=0, tmo=0.
  - Resulting outputs: grant_o=00, timeout_o=0, all s_* controls 0, all m*_ack_o/m*_err_o 0.
  - Applies mid-transfer: the owning master sees no ack. s_cyc_o drops the cycle after reset is sampled.
- Arbitration (evaluated in IDLE, and in OWNn on the cycle mn_cyc_i is low):
  - Only m0_cyc_i high -> OWN0.
  - Only m1_cyc_i high -> OWN1.
  - Both high -> grant the master != last. After reset, m0 wins the first tie.
  - Neither high -> IDLE.
  - On entering OWNn, last <= n.
- Latency: a request arriving in IDLE is granted at the next edge, so s_cyc_o rises one cycle after mn_cyc_i.
- Handover: when the owner drops cyc and the other master is requesting, ownership moves directly with no idle cycle between grants.
- While OWNn:
  - s_adr/dat/sel/we/cyc/stb_o = master n's inputs (combinational).
  - mn_ack_o = s_ack_i & ~tmo; mn_err_o = s_err_i | tmo.
  - The non-owner's ack/err are held 0.
  - A held cyc with multiple strobes (burst or RMW) keeps ownership and is never preempted.
- In IDLE: s_adr_o, s_dat_o, s_sel_o = 0 and s_we_o, s_cyc_o, s_stb_o = 0.
- grant_o reflects state (OWN0=01, OWN1=10).
- Watchdog (TIMEOUT>0):
  - stall = owner's stb high & ~s_ack_i & ~s_err_i & ~tmo.
  - cnt increments on stall. It clears on ack, err, tmo, or any state change.
  - When cnt==TIMEOUT-1 and stall, tmo<=1 at the next edge. tmo lasts exactly one cycle, which is the (TIMEOUT+1)th cycle of the unanswered strobe.
  - During tmo: s_cyc_o=s_stb_o=0, owner err=1, owner ack=0, timeout_o=1.
  - A s_ack_i arriving in the tmo cycle is discarded.
  - Ownership remains until the owner drops cyc.
  - cnt saturates; it does not wrap.
- Simultaneous events:
  - s_ack_i and s_err_i both high -> both forwarded; the master treats this as err.
  - Ack on the same cycle the count would expire -> no stall, so no timeout.

Test Plan:
1. m0 single read (adr 0x20000004), slave acks after 2 cycles with dat 0xDEADBEEF -> grant_o=01 one cycle after cyc; m0_ack_o one cycle; m0_dat_o=0xDEADBEEF; m1_ack_o=0; then grant_o=00.
2. Both cyc rise in the same cycle after reset, each doing 3 back-to-back single transfers -> owner order m0,m1,m0,m1,m0,m1; each handover has no idle cycle; the non-owner's ack is never seen.
3. m1 holds cyc for 4 strobes (0x40000000..0x4000000C) while m0 requests -> no m0 grant until m1 cyc drops; m0 owns the next cycle.
4. TIMEOUT=8, m0 strobes 0x70000000 with no slave response -> m0_err_o and timeout_o high exactly on the 9th cycle of the strobe; s_cyc_o low that cycle; a late s_ack_i that cycle is not forwarded.
5. TIMEOUT=0, slave stalls 2000 cycles, then acks -> no err; ack is forwarded.
6. reset asserted mid-transfer while m1 owns -> next cycle grant_o=00, s_cyc_o=0, acks 0; after release, a simultaneous request is won by m0.

Source files
------------

// File: rtl/wb_arbiter_rr2.sv
// Two-master round-robin Wishbone arbiter with a stalled-strobe watchdog.
// A granted master keeps the bus until it drops cyc.
module wb_arbiter_rr2 #(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic [31:0] m0_dat_o,
   input  logic [3:0]  m0_sel_i,
   input  logic        m0_we_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic [31:0] m1_dat_o,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_we_i,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic [3:0]  s_sel_o,
   output logic        s_we_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   input  logic        s_err_i,
   output logic [1:0]  grant_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   localparam logic [15:0] LIMIT =
      (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
   localparam bit WD_ON = (TIMEOUT != 0);

   state_t      state, state_n;
   logic        last, last_n;
   logic [15:0] cnt, cnt_n;
   logic        tmo, tmo_n;
   logic        own_cyc, own_stb;
   logic        stall, moving;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= '0;
         tmo   <= 1'b0;
      end else begin
         state <= state_n;
         last  <= last_n;
         cnt   <= cnt_n;
         tmo   <= tmo_n;
      end
   end

   always_comb begin
      own_cyc = 1'b0;
      own_stb = 1'b0;
      state_n = state;
      unique case (state)
         OWN0: begin
            own_cyc = m0_cyc_i;
            own_stb = m0_stb_i;
         end
         OWN1: begin
            own_cyc = m1_cyc_i;
            own_stb = m1_stb_i;
         end
         default: ;
      endcase
      // IDLE has no owner cyc, so it re-arbitrates every cycle too
      if (!own_cyc) begin
         unique case ({m1_cyc_i, m0_cyc_i})
            2'b01:   state_n = OWN0;
            2'b10:   state_n = OWN1;
            2'b11:   state_n = last ? OWN0 : OWN1;
            default: state_n = IDLE;
         endcase
      end
      moving = (state_n != state);
      last_n = last;
      if (moving && state_n != IDLE)
         last_n = (state_n == OWN1);
      stall = own_stb & ~s_ack_i & ~s_err_i & ~tmo;
      if (moving || s_ack_i || s_err_i || tmo)
         cnt_n = '0;
      else if (stall && cnt != 16'hFFFF)
         cnt_n = cnt + 16'd1;
      else
         cnt_n = cnt;
      tmo_n = WD_ON && stall && !moving && (cnt == LIMIT);
   end

   always_comb begin
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      s_we_o   = 1'b0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      unique case (state)
         OWN0: begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i & ~tmo;
            s_stb_o  = m0_stb_i & ~tmo;
            m0_ack_o = s_ack_i & ~tmo;
            m0_err_o = s_err_i | tmo;
         end
         OWN1: begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i & ~tmo;
            s_stb_o  = m1_stb_i & ~tmo;
            m1_ack_o = s_ack_i & ~tmo;
            m1_err_o = s_err_i | tmo;
         end
         default: ;
      endcase
   end

   assign m0_dat_o  = s_dat_i;
   assign m1_dat_o  = s_dat_i;
   assign grant_o   = state;
   assign timeout_o = tmo;

endmodule
